oplayback: RTL
==============

OPLAYBACK -- requirements
Module: oplayback

Interface
- REQ-001: Parameter HOLD_CYCLES, default 8; number of cycles each value is presented with disp_valid high; legal range 1..255.
- REQ-002: Parameter GAP_CYCLES, default 2; number of blank cycles after each value; legal range 1..255.
- REQ-003: clk  input  1; single clock; all state updates on the rising edge.
- REQ-004: rst  input  1; synchronous, active-high reset.
- REQ-005: start  input  1; begin playback; sampled only in IDLE.
- REQ-006: abort  input  1; cancel playback; sampled in every state.
- REQ-007: length_m1  input  5; number of entries to play minus one (0 = 1 entry, 31 = 32 entries); latched on accepted start.
- REQ-008: rd_addr  output  5; address into the 32x4 sequence RAM.
- REQ-009: rd_en  output  1; read strobe, one cycle per entry.
- REQ-010: rd_data  input  4; RAM read data, valid the cycle after rd_en.
- REQ-011: disp_val  output  4; value currently presented.
- REQ-012: disp_valid  output  1; disp_val is to be shown.
- REQ-013: busy  output  1; high in every state except IDLE.
- REQ-014: finish  output  1; one-cycle pulse on completion of a full playback.

Function
- REQ-015: FSM states: IDLE, READ, LATCH, SHOW, GAP, DONE.
- REQ-016: IDLE: when start=1 and abort=0, latch length_m1, clear idx to 0, go to READ; otherwise remain.
- REQ-017: READ: rd_en=1, rd_addr=idx for exactly one cycle; next state LATCH.
- REQ-018: LATCH: rd_en=0; at the end of the cycle, disp_val<=rd_data and disp_valid<=1; next state SHOW.
- REQ-019: SHOW: disp_valid=1 for exactly HOLD_CYCLES consecutive cycles (hold counter); next state GAP.
- REQ-020: GAP: disp_valid=0 for exactly GAP_CYCLES cycles; disp_val holds its last value; then go to DONE if idx==latched length_m1, else increment idx and go to READ.
- REQ-021: DONE: finish=1 for one cycle, idx cleared; next state IDLE.
- REQ-022: Per-entry period is 2+HOLD_CYCLES+GAP_CYCLES cycles; start-to-first-disp_valid latency is 3 cycles (start sampled at edge 0, disp_valid high after edge 2).
- REQ-023: rd_addr is driven with idx in all states; rd_en is high only in READ.
- REQ-024: start while busy=1 is ignored; length_m1 changes while busy=1 have no effect.
- REQ-025: abort=1 in any non-IDLE state forces IDLE at the next edge, with disp_valid=0, rd_en=0, idx=0, and no finish pulse; abort overrides start in the same cycle.
- REQ-026: idx is 5 bits; length_m1=31 plays addresses 0..31 and terminates through DONE without wrapping to 0 for a second pass.
- REQ-027: Illegal state encodings return to IDLE at the next edge with reset output values.

Reset
- REQ-028: rst=1 at an edge forces IDLE, idx=0, latched length=0, hold/gap counters=0, rd_en=0, rd_addr=0, disp_val=0, disp_valid=0, busy=0, finish=0.
- REQ-029: rst has priority over start and abort; rst asserted mid-playback abandons it with no finish pulse.

Verification
- REQ-030: HOLD=8, GAP=2, RAM[0..2]={5,A,3}, length_m1=2, start pulse -> rd_en pulses at addr 0,1,2 spaced 12 cycles apart; disp_val shows 5,A,3, each for 8 cycles, with 2 blank cycles between; finish single pulse 1 cycle after last gap; busy drops with finish.
- REQ-031: length_m1=0, RAM[0]=F -> one read of addr 0, disp_val=F for 8 cycles, finish after 13 cycles total from start.
- REQ-032: length_m1=31, RAM[i]=i[3:0] -> 32 reads, addresses 0..31 in order, no read of addr 0 after 31, exactly one finish.
- REQ-033: Abort asserted during 4th SHOW cycle of entry 1 -> next cycle IDLE, disp_valid=0, busy=0, no finish; subsequent start replays from addr 0.
- REQ-034: start re-pulsed and length_m1 changed mid-playback -> no effect on sequence length or timing.
- REQ-035: rst asserted during GAP -> all outputs at reset values the next cycle; no finish.

Source files
------------

// File: rtl/oplayback.sv
// ---------------------------------------------------------------------------
// oplayback -- sequenced value playback controller
//
// Reads up to 32 four-bit entries from an external 32x4 sequence RAM, one at
// a time, and presents each value on disp_val with disp_valid high for
// HOLD_CYCLES cycles, followed by GAP_CYCLES blank cycles. A one-cycle finish
// pulse marks the end of a complete playback; abort or rst abandons it
// silently.
//
// State table
//   IDLE  | waiting for start; length_m1 latched and idx cleared on accept
//   READ  | rd_en high for one cycle, rd_addr = idx
//   LATCH | RAM data arrives; captured into disp_val, disp_valid raised
//   SHOW  | disp_valid high, hold down-counter running
//   GAP   | disp_valid low, gap down-counter running; advance or finish
//   DONE  | finish pulse, idx cleared
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   start      in   1  begin playback (IDLE only)
//   abort      in   1  cancel playback (any non-IDLE state)
//   length_m1  in   5  entries to play minus one
//   rd_addr    out  5  sequence RAM address (always idx)
//   rd_en      out  1  sequence RAM read strobe
//   rd_data    in   4  sequence RAM data, valid the cycle after rd_en
//   disp_val   out  4  value being presented
//   disp_valid out  1  disp_val is to be shown
//   busy       out  1  high in every state except IDLE
//   finish     out  1  one-cycle pulse after a full playback
// ---------------------------------------------------------------------------
module oplayback #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] length_m1,
  output logic [4:0] rd_addr,
  output logic       rd_en,
  input  logic [3:0] rd_data,
  output logic [3:0] disp_val,
  output logic       disp_valid,
  output logic       busy,
  output logic       finish
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_SHOW  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Counters are loaded with N-1 and the state exits on terminal count 0,
  // giving exactly N cycles in SHOW / GAP.
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_idx;
  logic [4:0] r_len_m1;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gap_cnt;
  logic [3:0] r_disp_val;
  logic       r_disp_valid;

  logic       w_hold_tc;
  logic       w_gap_tc;
  logic       w_last;
  logic       w_accept;
  logic       w_abort;

  assign w_hold_tc = (r_hold_cnt == 8'd0);
  assign w_gap_tc  = (r_gap_cnt == 8'd0);
  assign w_last    = (r_idx == r_len_m1);
  assign w_accept  = start && !abort;
  // abort is ignored in IDLE; there it only suppresses start.
  assign w_abort   = abort && (r_state != S_IDLE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_READ : S_IDLE;
      S_READ:  w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_SHOW;
      S_SHOW:  w_state_nxt = w_hold_tc ? S_GAP : S_SHOW;
      S_GAP: begin
        if (!w_gap_tc) begin
          w_state_nxt = S_GAP;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers: index, latched length, counters, display value
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= 5'd0;
      r_len_m1     <= 5'd0;
      r_hold_cnt   <= 8'd0;
      r_gap_cnt    <= 8'd0;
      r_disp_val   <= 4'd0;
      r_disp_valid <= 1'b0;
    end else if (w_abort) begin
      // disp_val is left as is; only the valid flag is withdrawn.
      r_idx        <= 5'd0;
      r_hold_cnt   <= 8'd0;
      r_gap_cnt    <= 8'd0;
      r_disp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len_m1 <= length_m1;
            r_idx    <= 5'd0;
          end
        end
        S_READ: begin
        end
        S_LATCH: begin
          r_disp_val   <= rd_data;
          r_disp_valid <= 1'b1;
          r_hold_cnt   <= HOLD_LD;
        end
        S_SHOW: begin
          if (w_hold_tc) begin
            r_disp_valid <= 1'b0;
            r_gap_cnt    <= GAP_LD;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (!w_gap_tc) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end else if (!w_last) begin
            // No increment on the last entry, so idx never wraps from 31 to 0.
            r_idx <= r_idx + 5'd1;
          end
        end
        S_DONE: begin
          r_idx <= 5'd0;
        end
        default: begin
          // Illegal encoding: recover with reset values.
          r_idx        <= 5'd0;
          r_len_m1     <= 5'd0;
          r_hold_cnt   <= 8'd0;
          r_gap_cnt    <= 8'd0;
          r_disp_val   <= 4'd0;
          r_disp_valid <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    rd_addr    = r_idx;
    rd_en      = 1'b0;
    busy       = 1'b0;
    finish     = 1'b0;
    disp_val   = r_disp_val;
    disp_valid = r_disp_valid;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      S_LATCH: busy = 1'b1;
      S_SHOW:  busy = 1'b1;
      S_GAP:   busy = 1'b1;
      S_DONE: begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default: begin
        rd_addr    = 5'd0;
        disp_val   = 4'd0;
        disp_valid = 1'b0;
      end
    endcase
  end

endmodule
